// File: rtl/tile_pkg.sv
// Shared constants, types and helpers for the tile fetch pipeline.
package tile_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned TILE_SHIFT   = 3;
    localparam int unsigned MAP_COLS     = 80;
    localparam int unsigned MAP_ROWS     = 60;
    localparam int unsigned MAP_AW       = 13;
    localparam int unsigned PAT_AW       = 11;

    typedef logic [9:0] pix_coord_t;

    // Constant multiply as a sum of shifted copies; k is always an elaboration-time constant.
    function automatic logic [MAP_AW-1:0] shift_add(input logic [MAP_AW-1:0] a,
                                                    input int unsigned      k);
        logic [MAP_AW-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < MAP_AW; i++) begin
            if (((k >> i) & 32'd1) != 32'd0) begin
                acc = acc + (a << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Scrolled-coordinate wrap and tile-map address generation (purely combinational).
module tile_addr_gen
    import tile_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
    input  pix_coord_t        draw_x,
    input  pix_coord_t        draw_y,
    input  logic [9:0]        sx,
    input  logic [8:0]        sy,
    output logic [MAP_AW-1:0] map_addr_c,
    output logic [2:0]        col_c,
    output logic [2:0]        row_c,
    output logic              blank_c
);

    logic [10:0] sum_x;
    logic [10:0] sum_y;
    logic [9:0]  vx;
    logic [8:0]  vy;

    // A single conditional subtract suffices: both operands are already below the active size.
    always_comb begin
        sum_x = 11'(draw_x) + 11'(sx);
        sum_y = 11'(draw_y) + 11'(sy);
        vx    = (sum_x >= 11'(H_ACTIVE)) ? 10'(sum_x - 11'(H_ACTIVE)) : 10'(sum_x);
        vy    = (sum_y >= 11'(V_ACTIVE)) ? 9'(sum_y - 11'(V_ACTIVE))  : 9'(sum_y);
    end

    always_comb begin
        map_addr_c = shift_add(MAP_AW'(vy[8:TILE_SHIFT]), H_ACTIVE >> TILE_SHIFT)
                   + MAP_AW'(vx[9:TILE_SHIFT]);
        col_c      = vx[2:0];
        row_c      = vy[2:0];
        blank_c    = (11'(draw_x) >= 11'(H_ACTIVE)) || (11'(draw_y) >= 11'(V_ACTIVE));
    end

endmodule

// File: rtl/tile_fetcher.sv
// Per-pixel tile-map and pattern-row fetch, three register stages, one pixel per clock.
module tile_fetcher
    import tile_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              pixel_en,
    input  pix_coord_t        DrawX,
    input  pix_coord_t        DrawY,
    input  logic              frame_start,
    input  logic [9:0]        scroll_x,
    input  logic [8:0]        scroll_y,
    output logic [MAP_AW-1:0] map_addr,
    input  logic [7:0]        map_rdata,
    output logic [PAT_AW-1:0] pat_addr,
    input  logic [15:0]       pat_rdata,
    output logic [7:0]        export_pattern,
    output logic [1:0]        extend_color,
    output pix_coord_t        out_x,
    output pix_coord_t        out_y,
    output logic              out_valid
);

    logic [9:0]        sx;
    logic [8:0]        sy;

    logic [MAP_AW-1:0] map_addr_c;
    logic [2:0]        col_c;
    logic [2:0]        row_c;
    logic              blank_c;

    logic              v0;
    logic [2:0]        col0;
    logic [2:0]        row0;
    pix_coord_t        x0;
    pix_coord_t        y0;
    logic              blank0;

    logic              v1;
    logic [7:0]        code1;
    logic [2:0]        col1;
    pix_coord_t        x1;
    pix_coord_t        y1;
    logic              blank1;

    logic [1:0]        color_c;

    tile_addr_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_addr_gen (
        .draw_x     (DrawX),
        .draw_y     (DrawY),
        .sx         (sx),
        .sy         (sy),
        .map_addr_c (map_addr_c),
        .col_c      (col_c),
        .row_c      (row_c),
        .blank_c    (blank_c)
    );

    // Out-of-range scroll values fall back to zero; a strobe in the same cycle still sees the old values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sx <= '0;
            sy <= '0;
        end else if (frame_start) begin
            sx <= (11'(scroll_x) >= 11'(H_ACTIVE)) ? 10'd0 : scroll_x;
            sy <= (11'(scroll_y) >= 11'(V_ACTIVE)) ? 9'd0  : scroll_y;
        end
    end

    // Stage 0: map address; blanked pixels leave the address where it was.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            v0       <= 1'b0;
            map_addr <= '0;
            col0     <= '0;
            row0     <= '0;
            x0       <= '0;
            y0       <= '0;
            blank0   <= 1'b0;
        end else begin
            v0 <= pixel_en;
            if (pixel_en) begin
                if (!blank_c) begin
                    map_addr <= map_addr_c;
                end
                col0   <= col_c;
                row0   <= row_c;
                x0     <= DrawX;
                y0     <= DrawY;
                blank0 <= blank_c;
            end
        end
    end

    // Stage 1: pattern row address from the returned code.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            v1       <= 1'b0;
            pat_addr <= '0;
            code1    <= '0;
            col1     <= '0;
            x1       <= '0;
            y1       <= '0;
            blank1   <= 1'b0;
        end else begin
            v1 <= v0;
            if (v0) begin
                pat_addr <= {map_rdata, row0};
                code1    <= map_rdata;
                col1     <= col0;
                x1       <= x0;
                y1       <= y0;
                blank1   <= blank0;
            end
        end
    end

    // Pixel 0 sits in the top bit pair of the pattern row.
    always_comb begin
        color_c = 2'd0;
        case (col1)
            3'd0:    color_c = pat_rdata[15:14];
            3'd1:    color_c = pat_rdata[13:12];
            3'd2:    color_c = pat_rdata[11:10];
            3'd3:    color_c = pat_rdata[9:8];
            3'd4:    color_c = pat_rdata[7:6];
            3'd5:    color_c = pat_rdata[5:4];
            3'd6:    color_c = pat_rdata[3:2];
            default: color_c = pat_rdata[1:0];
        endcase
    end

    // Stage 2: outputs hold between valid pulses.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_valid      <= 1'b0;
            export_pattern <= '0;
            extend_color   <= '0;
            out_x          <= '0;
            out_y          <= '0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                export_pattern <= blank1 ? 8'd0 : code1;
                extend_color   <= blank1 ? 2'd0 : color_c;
                out_x          <= x1;
                out_y          <= y1;
            end
        end
    end

endmodule

// File: tb/tb_tile_fetcher.sv
// Directed and random stimulus against a scoreboard of independently modelled pixels.
module tb_tile_fetcher;
    import tile_pkg::*;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] code;
        logic [1:0] color;
    } exp_t;

    logic        Clk;
    logic        Reset;
    logic        pixel_en;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        frame_start;
    logic [9:0]  scroll_x;
    logic [8:0]  scroll_y;
    logic [12:0] map_addr;
    logic [7:0]  map_rdata;
    logic [10:0] pat_addr;
    logic [15:0] pat_rdata;
    logic [7:0]  export_pattern;
    logic [1:0]  extend_color;
    logic [9:0]  out_x;
    logic [9:0]  out_y;
    logic        out_valid;

    logic [7:0]  map_mem [0:8191];
    logic [15:0] pat_mem [0:2047];

    exp_t sb[$];
    int   checks     = 0;
    int   failures   = 0;
    int   valid_seen = 0;
    int   sx_m       = 0;
    int   sy_m       = 0;

    tile_fetcher dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .pixel_en       (pixel_en),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .frame_start    (frame_start),
        .scroll_x       (scroll_x),
        .scroll_y       (scroll_y),
        .map_addr       (map_addr),
        .map_rdata      (map_rdata),
        .pat_addr       (pat_addr),
        .pat_rdata      (pat_rdata),
        .export_pattern (export_pattern),
        .extend_color   (extend_color),
        .out_x          (out_x),
        .out_y          (out_y),
        .out_valid      (out_valid)
    );

    assign map_rdata = map_mem[map_addr];
    assign pat_rdata = pat_mem[pat_addr];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input int x, input int y, input int sxv, input int syv);
        exp_t e;
        int vx, vy, addr, col, row;
        logic [15:0] w;
        e.x = 10'(x);
        e.y = 10'(y);
        e.code = 8'd0;
        e.color = 2'd0;
        if (x < 640 && y < 480) begin
            vx = x + sxv;
            if (vx >= 640) vx = vx - 640;
            vy = y + syv;
            if (vy >= 480) vy = vy - 480;
            addr = (vy / 8) * 80 + (vx / 8);
            col = vx % 8;
            row = vy % 8;
            e.code = map_mem[addr];
            w = pat_mem[int'(e.code) * 8 + row];
            e.color = 2'((w >> (14 - 2 * col)) & 16'd3);
        end
        return e;
    endfunction

    task automatic drive(input logic pe, input int x, input int y,
                         input logic fs, input int scx, input int scy);
        pixel_en    = pe;
        DrawX       = 10'(x);
        DrawY       = 10'(y);
        frame_start = fs;
        scroll_x    = 10'(scx);
        scroll_y    = 9'(scy);
        if (pe) sb.push_back(model(x, y, sx_m, sy_m));
        if (fs) begin
            sx_m = (scx >= 640) ? 0 : scx;
            sy_m = (scy >= 480) ? 0 : scy;
        end
        @(posedge Clk);
        #1;
        pixel_en    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_map_addr"}, 32'(map_addr), 0);
        chk({tag, "_pat_addr"}, 32'(pat_addr), 0);
        chk({tag, "_export_pattern"}, 32'(export_pattern), 0);
        chk({tag, "_extend_color"}, 32'(extend_color), 0);
        chk({tag, "_out_x"}, 32'(out_x), 0);
        chk({tag, "_out_y"}, 32'(out_y), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
    endtask

    // Every output pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (!Reset && out_valid) begin
            exp_t e;
            valid_seen++;
            chk("sb_has_entry", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_x", 32'(out_x), 32'(e.x));
                chk("out_y", 32'(out_y), 32'(e.y));
                chk("export_pattern", 32'(export_pattern), 32'(e.code));
                chk("extend_color", 32'(extend_color), 32'(e.color));
            end
        end
    end

    initial begin
        logic [12:0] ma_hold;
        int base;

        Reset = 1'b1;
        pixel_en = 1'b0;
        DrawX = '0;
        DrawY = '0;
        frame_start = 1'b0;
        scroll_x = '0;
        scroll_y = '0;
        for (int i = 0; i < 8192; i++) map_mem[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) pat_mem[i] = 16'($urandom);
        map_mem[81]  = 8'h2A;
        pat_mem[338] = 16'h1B00;
        map_mem[1]   = 8'h51;

        repeat (3) @(posedge Clk);
        #1;
        chk_zero("reset");
        Reset = 1'b0;
        idle(1);

        // Unscrolled pixel: address, latency and data.
        drive(1'b1, 13, 10, 1'b0, 0, 0);
        chk("t1_map_addr", 32'(map_addr), 81);
        chk("t1_valid_n1", 32'(out_valid), 0);
        idle(1);
        chk("t1_pat_addr", 32'(pat_addr), 338);
        chk("t1_valid_n2", 32'(out_valid), 0);
        idle(1);
        chk("t1_valid_n3", 32'(out_valid), 1);
        idle(2);

        // Scroll wraps in both axes.
        drive(1'b0, 0, 0, 1'b1, 636, 478);
        drive(1'b1, 10, 5, 1'b0, 0, 0);
        chk("t2_map_addr", 32'(map_addr), 0);
        idle(4);

        // Back-to-back strobes give back-to-back pulses.
        base = valid_seen;
        for (int i = 0; i < 5; i++) drive(1'b1, i, 20, 1'b0, 0, 0);
        idle(3);
        chk("t3_valid_after", 32'(out_valid), 0);
        chk("t3_pulse_count", 32'(valid_seen - base), 5);

        // Blank pixel keeps map address; oversize scroll latches as zero.
        ma_hold = map_addr;
        drive(1'b1, 700, 30, 1'b0, 0, 0);
        chk("t4_map_addr_hold", 32'(map_addr), 32'(ma_hold));
        drive(1'b0, 0, 0, 1'b1, 700, 500);
        drive(1'b1, 13, 10, 1'b0, 0, 0);
        chk("t4_scroll_clamp", 32'(map_addr), 81);
        drive(1'b1, 20, 479, 1'b0, 0, 0);
        drive(1'b1, 20, 480, 1'b0, 0, 0);
        idle(4);

        // Same-cycle frame_start: old scroll for this pixel, new one next.
        drive(1'b1, 0, 0, 1'b1, 8, 0);
        chk("t5_old_scroll", 32'(map_addr), 0);
        drive(1'b1, 0, 0, 1'b0, 0, 0);
        chk("t5_new_scroll", 32'(map_addr), 1);
        idle(4);

        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 719)),
                  int'($urandom_range(0, 519)), 1'($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)));
        end
        idle(5);

        // Reset mid-stream discards in-flight pixels.
        base = valid_seen;
        drive(1'b1, 3, 3, 1'b0, 0, 0);
        drive(1'b1, 4, 4, 1'b0, 0, 0);
        Reset = 1'b1;
        sb.delete();
        sx_m = 0;
        sy_m = 0;
        idle(2);
        chk_zero("midrst");
        Reset = 1'b0;
        idle(3);
        chk_zero("postrst");
        chk("postrst_no_pulse", 32'(valid_seen - base), 0);
        drive(1'b1, 13, 10, 1'b0, 0, 0);
        idle(1);
        chk("postrst_valid_n2", 32'(out_valid), 0);
        idle(1);
        chk("postrst_valid_n3", 32'(out_valid), 1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
